dsp_cascade_ctrl: RTL and testbench
===================================

// Module: dsp_cascade_ctrl
// PURPOSE
//   Configuration and timing controller for the 5-tap DSP cascade in the HDMI convolution filter.
//   Accepts coefficient writes over a valid/ready port into a shadow bank.
//   Swaps the shadow bank into the active bank only at a frame boundary (rising vs_in).
//   Delays de/hs/vs by the cascade latency so syncs stay aligned with p_out.
// PARAMETERS
//   NTAPS      5    number of cascade taps (pa..pe)
//   COEF_W     8    coefficient width, two's complement
//   LAT        6    cascade latency in clk cycles, from pa..pe to p_out; >=1
//   RST_CENTER 8'h01  reset value of centre tap (index NTAPS/2); all other taps reset to 0
// PORTS
//   clk          in   1              pixel clock, rising edge
//   rst          in   1              asynchronous reset, active-low
//   cfg_valid    in   1              coefficient write request
//   cfg_ready    out  1              write accepted when cfg_valid & cfg_ready
//   cfg_addr     in   3              tap index 0..NTAPS-1
//   cfg_data     in   COEF_W         coefficient value
//   cfg_commit   in   1              one-cycle pulse: shadow bank complete, swap at next frame
//   vs_in        in   1              vertical sync, aligned with pa..pe
//   hs_in        in   1              horizontal sync, aligned with pa..pe
//   de_in        in   1              data enable, aligned with pa..pe
//   coef_out     out  NTAPS*COEF_W   active bank; tap i at [i*COEF_W +: COEF_W]
//   vs_out       out  1              vs_in delayed by LAT cycles
//   hs_out       out  1              hs_in delayed by LAT cycles
//   de_out       out  1              de_in delayed by LAT cycles
//   swap_pending out  1              commit seen, swap not yet done
//   swap_done    out  1              one-cycle pulse when the active bank updates
//   cfg_err      out  1              sticky: write seen with cfg_addr >= NTAPS
// BEHAVIOUR
//   Reset (rst=0, async):
//     - Shadow and active banks: centre tap = RST_CENTER, all others 0.
//     - Delay lines, swap_pending, swap_done and cfg_err = 0.
//     - FSM returns to IDLE; cfg_ready = 0 while in reset.
//   FSM states:
//     - IDLE:    cfg_ready=1. A write updates shadow[cfg_addr] on the same edge. cfg_commit -> ARMED.
//     - ARMED:   cfg_ready=0, swap_pending=1. vs_rise (vs_in=1 and previous vs_in=0) -> SWAP.
//     - SWAP:    one cycle. active <= shadow; swap_done=1. Next state IDLE.
//   Accepted-write rules:
//     - Write and cfg_commit in the same IDLE cycle: the write is included in the committed bank.
//     - cfg_commit outside IDLE is ignored. A commit with no prior writes is legal and re-swaps the same values.
//     - cfg_addr >= NTAPS: shadow unchanged, cfg_err set; cleared only by reset.
//   Edge detection:
//     - vs_in is sampled into a register; vs_rise is derived from that register.
//     - A vs_rise in the same cycle as cfg_commit does NOT swap; the swap waits for the next rising edge.
//   Timing:
//     - coef_out changes exactly one cycle after the ARMED-state edge that sees vs_rise.
//       It stays constant for the rest of the frame.
//   Delay lines: LAT-deep shift registers, no enable; out(t) = in(t-LAT).
//   Reset mid-ARMED: the pending commit is discarded and the active bank returns to its reset values.
// STRUCTURE
//   Shared package (dsp_cascade_pkg):
//     - NTAPS, COEF_W, LAT.
//     - FSM state encoding: IDLE=2'd0, ARMED=2'd1, SWAP=2'd2.
//     - Coefficient reset constant.
//   Sub-module sync_delay #(.W(3), .D(LAT)): de/hs/vs delay line, async active-low reset.
//   The bank registers and the FSM stay in the top module.
// TESTING
//   1. Reset release:
//      coef_out = 40'h0000010000 (centre=1); cfg_ready=1 one cycle after rst deasserts; de/hs/vs_out=0.
//   2. Write 5 taps {1,2,4,2,1}, then commit:
//      - swap_pending=1 and coef_out unchanged until vs_rise.
//      - One cycle after the vs_rise edge: coef_out = 40'h0102040201 and swap_done pulses for 1 cycle.
//   3. Commit in the same cycle as vs_rise:
//      - No swap on that edge.
//      - Swap only on the following vs_rise; cfg_ready stays 0 throughout ARMED.
//   4. Write cfg_addr=5:
//      - cfg_err=1 and stays 1; shadow unchanged.
//      - A subsequent commit+vs_rise shows the old values.
//   5. Toggle de_in/hs_in/vs_in with a 32-cycle counter pattern:
//      each *_out equals its input delayed by exactly LAT=6 cycles, checked each cycle.
//   6. Assert rst=0 mid-ARMED:
//      - Immediately: swap_pending=0 and coef_out = reset bank.
//      - After release: a vs_rise produces no swap_done.

Source files
------------

// File: rtl/dsp_cascade_pkg.sv
// Shared constants, FSM encoding and bank reset value for the 5-tap DSP cascade controller.
package dsp_cascade_pkg;
    localparam int NTAPS  = 5;
    localparam int COEF_W = 8;
    localparam int LAT    = 6;
    localparam int ADDR_W = 3;
    localparam int BANK_W = NTAPS * COEF_W;

    localparam logic [COEF_W-1:0] RST_CENTER = 8'h01;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SWAP  = 2'd2
    } state_e;

    // Centre tap passes the pixel through unchanged; every other tap is zero.
    function automatic logic [BANK_W-1:0] coef_reset();
        logic [BANK_W-1:0] v;
        v = '0;
        v[(NTAPS/2)*COEF_W +: COEF_W] = RST_CENTER;
        return v;
    endfunction
endpackage

// File: rtl/sync_delay.sv
// Fixed-depth shift register that keeps de/hs/vs aligned with the cascade output.
module sync_delay #(
    parameter int W = 1,
    parameter int D = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [D-1:0][W-1:0] pipe_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < D; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign q_o = pipe_q[D-1];
endmodule

// File: rtl/dsp_cascade_ctrl.sv
// Coefficient shadow/active bank controller with frame-aligned swap and sync delay for the
// HDMI convolution cascade.
module dsp_cascade_ctrl
    import dsp_cascade_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    input  logic [ADDR_W-1:0] cfg_addr_i,
    input  logic [COEF_W-1:0] cfg_data_i,
    input  logic              cfg_commit_i,
    input  logic              vs_in_i,
    input  logic              hs_in_i,
    input  logic              de_in_i,
    output logic [BANK_W-1:0] coef_out_o,
    output logic              vs_out_o,
    output logic              hs_out_o,
    output logic              de_out_o,
    output logic              swap_pending_o,
    output logic              swap_done_o,
    output logic              cfg_err_o
);
    localparam logic [ADDR_W-1:0] NTAPS_A = ADDR_W'(NTAPS);

    state_e            state_q, state_d;
    logic [BANK_W-1:0] shadow_q, shadow_d;
    logic [BANK_W-1:0] active_q, active_d;
    logic              cfg_err_q, cfg_err_d;
    logic              rdy_en_q;
    logic              vs_q;
    logic              swap_done_q;
    logic              vs_rise;

    assign vs_rise = vs_in_i & ~vs_q;

    // rdy_en_q holds cfg_ready low through reset and the first cycle after release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            shadow_q    <= coef_reset();
            active_q    <= coef_reset();
            cfg_err_q   <= 1'b0;
            rdy_en_q    <= 1'b0;
            vs_q        <= 1'b0;
            swap_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            cfg_err_q   <= cfg_err_d;
            rdy_en_q    <= 1'b1;
            vs_q        <= vs_in_i;
            swap_done_q <= (state_q == SWAP);
        end
    end

    always_comb begin
        state_d        = state_q;
        shadow_d       = shadow_q;
        active_d       = active_q;
        cfg_err_d      = cfg_err_q;
        cfg_ready_o    = 1'b0;
        swap_pending_o = 1'b0;
        case (state_q)
            IDLE: begin
                cfg_ready_o = rdy_en_q;
                if (rdy_en_q) begin
                    if (cfg_valid_i) begin
                        if (cfg_addr_i < NTAPS_A) begin
                            for (int i = 0; i < NTAPS; i++) begin
                                if (cfg_addr_i == ADDR_W'(i)) begin
                                    shadow_d[i*COEF_W +: COEF_W] = cfg_data_i;
                                end
                            end
                        end else begin
                            cfg_err_d = 1'b1;
                        end
                    end
                    // A write in the commit cycle already lands in shadow_d, so it is swapped too.
                    if (cfg_commit_i) begin
                        state_d = ARMED;
                    end
                end
            end
            ARMED: begin
                swap_pending_o = 1'b1;
                if (vs_rise) begin
                    state_d = SWAP;
                end
            end
            SWAP: begin
                active_d = shadow_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign coef_out_o  = active_q;
    assign swap_done_o = swap_done_q;
    assign cfg_err_o   = cfg_err_q;

    sync_delay #(
        .W(3),
        .D(LAT)
    ) u_sync_delay (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .d_i   ({de_in_i, hs_in_i, vs_in_i}),
        .q_o   ({de_out_o, hs_out_o, vs_out_o})
    );
endmodule

// File: tb/tb_dsp_cascade_ctrl.sv
// Self-checking bench for dsp_cascade_ctrl: constant-expectation vectors plus a frame-level reference model.
module tb_dsp_cascade_ctrl;
    import dsp_cascade_pkg::*;

    localparam logic [39:0] RST_BANK = 40'h0000010000;
    localparam logic [39:0] BANK_A   = 40'h0102040201;
    localparam logic [39:0] BANK_B   = 40'h0102100201;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid, cfg_commit, vs_in, hs_in, de_in;
    logic [2:0]  cfg_addr;
    logic [7:0]  cfg_data;
    logic        cfg_ready, vs_out, hs_out, de_out, swap_pending, swap_done, cfg_err;
    logic [39:0] coef_out;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dsp_cascade_ctrl dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .cfg_valid_i   (cfg_valid),
        .cfg_ready_o   (cfg_ready),
        .cfg_addr_i    (cfg_addr),
        .cfg_data_i    (cfg_data),
        .cfg_commit_i  (cfg_commit),
        .vs_in_i       (vs_in),
        .hs_in_i       (hs_in),
        .de_in_i       (de_in),
        .coef_out_o    (coef_out),
        .vs_out_o      (vs_out),
        .hs_out_o      (hs_out),
        .de_out_o      (de_out),
        .swap_pending_o(swap_pending),
        .swap_done_o   (swap_done),
        .cfg_err_o     (cfg_err)
    );

    // Reference model: coefficient arrays, a "commit waiting for frame" flag and a sync history queue.
    logic [7:0] m_shadow [5];
    logic [7:0] m_active [5];
    bit         m_pending, m_swap_now, m_err, m_prev_vs, m_rdy_en, m_done;
    logic [2:0] m_hist [$];
    logic [2:0] m_exp_sync;

    typedef struct {
        bit          v;
        logic [2:0]  a;
        logic [7:0]  d;
        bit          c;
        bit          vs;
        bit          e_rdy;
        bit          e_pend;
        bit          e_done;
        logic [39:0] e_coef;
    } vec_t;

    vec_t tv [9];

    function automatic logic [39:0] model_bank();
        logic [39:0] b;
        for (int i = 0; i < 5; i++) b[i*8 +: 8] = m_active[i];
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 5; i++) begin
            m_shadow[i] = (i == 2) ? 8'h01 : 8'h00;
            m_active[i] = m_shadow[i];
        end
        m_pending = 0; m_swap_now = 0; m_err = 0; m_prev_vs = 0; m_rdy_en = 0; m_done = 0;
        m_hist.delete();
        // Push-then-pop each cycle, so LAT-1 zeros give an LAT-cycle delay.
        for (int i = 0; i < LAT - 1; i++) m_hist.push_back(3'b000);
        m_exp_sync = 3'b000;
    endtask

    task automatic model_step(input bit v, input logic [2:0] a, input logic [7:0] d,
                              input bit c, input bit vs, input bit hs, input bit de);
        m_done = m_swap_now;
        if (m_swap_now) begin
            for (int i = 0; i < 5; i++) m_active[i] = m_shadow[i];
            m_swap_now = 0;
        end else if (m_pending) begin
            if (vs && !m_prev_vs) begin
                m_pending  = 0;
                m_swap_now = 1;
            end
        end else if (m_rdy_en) begin
            if (v) begin
                if (a < 3'd5) m_shadow[a] = d;
                else m_err = 1;
            end
            if (c) m_pending = 1;
        end
        m_rdy_en  = 1;
        m_prev_vs = vs;
        m_hist.push_back({de, hs, vs});
        m_exp_sync = m_hist.pop_front();
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("m_coef", coef_out, model_bank());
        chk("m_ready", cfg_ready, m_rdy_en && !m_pending && !m_swap_now);
        chk("m_pending", swap_pending, m_pending);
        chk("m_done", swap_done, m_done);
        chk("m_err", cfg_err, m_err);
        chk("m_sync", {de_out, hs_out, vs_out}, m_exp_sync);
    endtask

    // Called at a negedge: drive, clock once, check at the following negedge.
    task automatic cyc(input bit v, input logic [2:0] a, input logic [7:0] d,
                       input bit c, input bit vs, input bit hs, input bit de);
        cfg_valid = v; cfg_addr = a; cfg_data = d; cfg_commit = c;
        vs_in = vs; hs_in = hs; de_in = de;
        model_step(v, a, d, c, vs, hs, de);
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic idle(input bit vs);
        cyc(0, 3'd0, 8'h00, 0, vs, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 0;
        cfg_valid = 0; cfg_addr = 0; cfg_data = 0; cfg_commit = 0;
        vs_in = 0; hs_in = 0; de_in = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_coef", coef_out, RST_BANK);
        chk("rst_ready", cfg_ready, 1'b0);
        chk("rst_sync", {de_out, hs_out, vs_out}, 3'b000);
        chk("rst_flags", {swap_pending, swap_done, cfg_err}, 3'b000);
        rst_n = 1;
        #1 chk("rel_ready_low", cfg_ready, 1'b0);
    endtask

    initial begin
        tv[0] = '{1, 3'd0, 8'h01, 0, 0, 1, 0, 0, RST_BANK};
        tv[1] = '{1, 3'd1, 8'h02, 0, 0, 1, 0, 0, RST_BANK};
        tv[2] = '{1, 3'd2, 8'h04, 0, 0, 1, 0, 0, RST_BANK};
        tv[3] = '{1, 3'd3, 8'h02, 0, 0, 1, 0, 0, RST_BANK};
        tv[4] = '{1, 3'd4, 8'h01, 1, 0, 0, 1, 0, RST_BANK};
        tv[5] = '{0, 3'd0, 8'h00, 0, 0, 0, 1, 0, RST_BANK};
        tv[6] = '{0, 3'd0, 8'h00, 0, 1, 0, 0, 0, RST_BANK};
        tv[7] = '{0, 3'd0, 8'h00, 0, 1, 1, 0, 1, BANK_A};
        tv[8] = '{0, 3'd0, 8'h00, 0, 1, 1, 0, 0, BANK_A};

        rst_n = 0;
        cfg_valid = 0; cfg_addr = 0; cfg_data = 0; cfg_commit = 0;
        vs_in = 0; hs_in = 0; de_in = 0;
        @(negedge clk);

        // Reset release: ready rises one cycle after deassertion.
        do_reset();
        idle(0);
        chk("t1_ready", cfg_ready, 1'b1);
        chk("t1_coef", coef_out, RST_BANK);

        // Write {1,2,4,2,1}, commit, swap on vs rise.
        for (int k = 0; k < 9; k++) begin
            cyc(tv[k].v, tv[k].a, tv[k].d, tv[k].c, tv[k].vs, 0, 0);
            chk($sformatf("tv%0d_ready", k), cfg_ready, tv[k].e_rdy);
            chk($sformatf("tv%0d_pend", k), swap_pending, tv[k].e_pend);
            chk($sformatf("tv%0d_done", k), swap_done, tv[k].e_done);
            chk($sformatf("tv%0d_coef", k), coef_out, tv[k].e_coef);
        end

        // Commit (with a write) on the same edge as a vs rise: swap waits for the next rise.
        idle(0);
        cyc(1, 3'd2, 8'h10, 1, 1, 0, 0);
        chk("t3_pend0", swap_pending, 1'b1);
        for (int k = 0; k < 3; k++) begin
            idle(k < 2);
            chk("t3_ready_armed", cfg_ready, 1'b0);
            chk("t3_no_done", swap_done, 1'b0);
            chk("t3_coef_hold", coef_out, BANK_A);
        end
        idle(1);
        chk("t3_swap_state", {swap_pending, swap_done}, 2'b00);
        idle(1);
        chk("t3_done", swap_done, 1'b1);
        chk("t3_coef", coef_out, BANK_B);
        idle(0);
        chk("t3_done_pulse", swap_done, 1'b0);

        // Out-of-range write: sticky error, shadow untouched.
        cyc(1, 3'd5, 8'h77, 0, 0, 0, 0);
        chk("t4_err", cfg_err, 1'b1);
        cyc(0, 3'd0, 8'h00, 1, 0, 0, 0);
        idle(1);
        idle(1);
        chk("t4_done", swap_done, 1'b1);
        chk("t4_coef_old", coef_out, BANK_B);
        chk("t4_err_sticky", cfg_err, 1'b1);

        // 32-cycle counter pattern on the syncs, checked against the model history each cycle.
        for (int k = 0; k < 64; k++) begin
            logic [4:0] cnt;
            cnt = 5'(k);
            cyc(0, 3'd0, 8'h00, 0, cnt >= 5'd30, cnt[1] ^ cnt[3], cnt < 5'd20);
        end

        // Randomised traffic.
        for (int k = 0; k < 400; k++) begin
            cyc(($urandom % 2) == 0, 3'($urandom_range(0, 7)), 8'($urandom),
                ($urandom % 8) == 0, ($urandom % 4) == 0,
                ($urandom % 2) == 0, ($urandom % 2) == 0);
        end

        // Reset while armed: commit discarded, bank back to reset values.
        do_reset();
        idle(0);
        cyc(1, 3'd0, 8'h55, 1, 0, 0, 0);
        idle(0);
        chk("t6_armed", swap_pending, 1'b1);
        #2 rst_n = 0;
        #1;
        chk("t6_pend_clr", swap_pending, 1'b0);
        chk("t6_coef_rst", coef_out, RST_BANK);
        chk("t6_ready_rst", cfg_ready, 1'b0);
        cfg_valid = 0; cfg_commit = 0; vs_in = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
        idle(0);
        for (int k = 0; k < 3; k++) begin
            idle(1);
            chk("t6_no_done", swap_done, 1'b0);
            chk("t6_coef", coef_out, RST_BANK);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
